// File: rtl/display_pkg.sv
// Shared types and seven-segment encodings for the result display path.
// Segment bit order is {g,f,e,d,c,b,a}, active-low.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_Q = 2'd1,
    CONV_R = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_Q     = 7'b0011000;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Codes 10..15 never come out of a correct conversion; show them as blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 converter: N-bit binary to three BCD digits,
// one iteration per clock; the first iteration happens on the start edge.
module bin2bcd_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic [11:0]  bcd
);

  localparam int SW = 12 + N;
  localparam int CW = $clog2(N + 1);

  logic [SW-1:0] r_sr;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [SW-1:0] w_step_in;
  logic [SW-1:0] w_step_out;

  function automatic logic [SW-1:0] dabble(input logic [SW-1:0] sr);
    logic [SW-1:0] t;
    t = sr;
    for (int i = 0; i < 3; i++) begin
      if (t[N+4*i +: 4] >= 4'd5) t[N+4*i +: 4] = t[N+4*i +: 4] + 4'd3;
    end
    return {t[SW-2:0], 1'b0};
  endfunction

  // A start seeds the register with a cleared BCD field so the previous pass never leaks in.
  assign w_step_in  = start ? {12'd0, bin} : r_sr;
  assign w_step_out = dabble(w_step_in);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_sr   <= w_step_out;
        r_cnt  <= CW'(1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_sr  <= w_step_out;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(N - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_sr[SW-1:N];

endmodule

// File: rtl/result_display_driver.sv
// Converts a captured quotient/remainder pair to BCD and drives a 4-digit
// multiplexed seven-segment display showing a q/r tag plus three digits.
module result_display_driver #(
  parameter int N           = 8,
  parameter int REFRESH_DIV = 50_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] r_i,
  input  logic         load_i,
  input  logic         show_r_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [3:0]   an_o,
  output logic [6:0]   seg_o
);

  import display_pkg::*;

  localparam int RW = $clog2(REFRESH_DIV);

  state_t        r_state;
  state_t        w_next;
  logic [N-1:0]  r_rem;
  logic [11:0]   r_bcd_q;
  logic [11:0]   r_bcd_r;
  logic [11:0]   r_disp_q;
  logic [11:0]   r_disp_r;
  logic          w_start;
  logic [N-1:0]  w_bin;
  logic          w_conv_busy;
  logic          w_conv_done;
  logic [11:0]   w_conv_bcd;

  bin2bcd_seq #(.N(N)) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .bin   (w_bin),
    .busy  (w_conv_busy),
    .done  (w_conv_done),
    .bcd   (w_conv_bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Q is fed straight from q_i on the load edge; R waits in r_rem for the second pass.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_bin   = r_rem;
    case (r_state)
      IDLE: begin
        if (load_i) begin
          w_start = 1'b1;
          w_bin   = q_i;
          w_next  = CONV_Q;
        end
      end
      CONV_Q: begin
        if (w_conv_done) begin
          w_start = 1'b1;
          w_next  = CONV_R;
        end
      end
      CONV_R:  if (w_conv_done) w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem    <= '0;
      r_bcd_q  <= '0;
      r_bcd_r  <= '0;
      r_disp_q <= '0;
      r_disp_r <= '0;
    end else begin
      if (r_state == IDLE && load_i)       r_rem   <= r_i;
      if (r_state == CONV_Q && w_conv_done) r_bcd_q <= w_conv_bcd;
      if (r_state == CONV_R && w_conv_done) r_bcd_r <= w_conv_bcd;
      if (r_state == COMMIT) begin
        r_disp_q <= r_bcd_q;
        r_disp_r <= r_bcd_r;
      end
    end
  end

  assign busy_o = (r_state != IDLE) || w_conv_busy;
  assign done_o = (r_state == COMMIT);

  logic [RW-1:0] r_refresh;
  logic [1:0]    r_digit;
  logic [1:0]    w_digit_next;
  logic          w_wrap;
  logic [11:0]   w_sel;
  logic [6:0]    w_seg_next;
  logic [3:0]    w_an_next;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;

  assign w_wrap       = (r_refresh == RW'(REFRESH_DIV - 1));
  assign w_digit_next = w_wrap ? r_digit + 2'd1 : r_digit;
  assign w_sel        = show_r_i ? r_disp_r : r_disp_q;
  assign w_an_next    = ~(4'b0001 << w_digit_next);

  // Segments are computed for the digit that will be enabled after this edge.
  always_comb begin
    w_seg_next = SEG_BLANK;
    case (w_digit_next)
      2'd3: w_seg_next = show_r_i ? SEG_R : SEG_Q;
      2'd2: w_seg_next = (w_sel[11:8] == 4'd0) ? SEG_BLANK : bcd_to_seg(w_sel[11:8]);
      2'd1: w_seg_next = (w_sel[11:4] == 8'd0) ? SEG_BLANK : bcd_to_seg(w_sel[7:4]);
      default: w_seg_next = bcd_to_seg(w_sel[3:0]);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh <= '0;
      r_digit   <= 2'd0;
      r_an      <= 4'b1110;
      r_seg     <= SEG_0;
    end else begin
      r_refresh <= w_wrap ? '0 : r_refresh + 1'b1;
      r_digit   <= w_digit_next;
      r_an      <= w_an_next;
      r_seg     <= w_seg_next;
    end
  end

  assign an_o  = r_an;
  assign seg_o = r_seg;

endmodule

// File: doc/result_display_driver.md
# result_display_driver

Sequential back end of the calculator datapath: captures the quotient and remainder from `divisor`, converts each from binary to three BCD digits with a shift-and-add-3 (double-dabble) sequence, and drives a 4-digit multiplexed seven-segment display. It is the output-side counterpart of the keypad input FSM, which builds binary operands from decimal key presses; this block turns binary results back into decimal digits.

## Interface
- `N`, 8: operand/result width; legal range 4..9, so results always fit in 3 BCD digits.
- `REFRESH_DIV`, 50_000: clock cycles each digit stays enabled; minimum 2.
- `clk` in 1: single clock; all state on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `q_i` in N: quotient from `divisor`.
- `r_i` in N: remainder from `divisor`.
- `load_i` in 1: one-cycle strobe that captures `q_i`/`r_i` and starts conversion.
- `show_r_i` in 1: 0 displays the quotient, 1 displays the remainder; level-sensitive.
- `busy_o` out 1: conversion in progress.
- `done_o` out 1: one-cycle pulse when new display values are committed.
- `an_o` out 4: digit enables, active-low, one-hot-low.
- `seg_o` out 7: {g,f,e,d,c,b,a}, active-low.

## Operation
- FSM states: IDLE, CONV_Q, CONV_R, COMMIT.
- IDLE: if `load_i`=1, register `q_i`/`r_i`, clear the BCD shift register, go to CONV_Q. `load_i` is ignored in every other state.
- CONV_Q: N double-dabble iterations on the captured Q, one per cycle. Each iteration adds 3 to every BCD nibble ≥5, then shifts left by one, bringing in the binary MSB. After N iterations, store 12-bit BCD_Q and go to CONV_R.
- CONV_R: same sequence on the captured R, producing BCD_R; then go to COMMIT.
- COMMIT: copy BCD_Q and BCD_R into the display registers together, pulse `done_o`, return to IDLE. The displayed values never show a half-converted result.
- Display digit 3 (leftmost) shows a tag: 'q' = 7'b0011000 when `show_r_i`=0, 'r' = 7'b0101111 when `show_r_i`=1.
- Digits 2..0 show hundreds, tens and units of the selected value.
- Leading-zero blanking: hundreds are blank if 0; tens are blank if both hundreds and tens are 0; units are always shown. Blank = 7'b1111111.
- Digit codes 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. A nibble greater than 9 cannot occur; if one does, display blank.
- Scanner: a refresh counter runs 0..REFRESH_DIV-1; on wrap the digit index advances 0→1→2→3→0. `an_o` and `seg_o` are registered and change on the same edge.

## Timing
- Reset values: state=IDLE, `busy_o`=0, `done_o`=0, display registers=0, refresh counter=0, digit index=0, `an_o`=4'b1110, `seg_o`=digit-0 code for 0 (1000000). After reset the display reads "q  0".
- Load accepted at edge T: `busy_o`=1 from T+1 through T+2N+1.
- `done_o`=1 in cycle T+2N+1 only.
- New display registers are valid from T+2N+2; IDLE is also reached at T+2N+2.
- A `load_i` at T+2N+2 is accepted, so back-to-back loads have a period of 2N+2 cycles.
- `show_r_i` change: takes effect at the next scanner register update, within 1 cycle.
- Each digit is enabled for exactly REFRESH_DIV cycles; a full frame is 4·REFRESH_DIV cycles.
- Reset asserted mid-conversion: all state returns to reset values immediately; the partial result is discarded and `done_o` does not pulse.
- Conversion and scanning are independent; scanning never stalls.

## Structure
- Package `display_pkg`:
  - FSM state enum;
  - 7-bit segment constants SEG_0..SEG_9, SEG_Q, SEG_R, SEG_BLANK;
  - function `bcd_to_seg`.
- Sub-module `bin2bcd_seq #(N)`:
  - ports: clk, rst, start, bin, busy, done, bcd[11:0];
  - one instance reused for both passes, sequenced by the top FSM.
- Top: capture registers, FSM, display registers, refresh counter/scanner.

## Test plan
Use REFRESH_DIV=4 and N=8 for all scenarios.
- Reset → `an_o`=1110, `seg_o`=1000000, `busy_o`=0; one frame shows digits [tag q, blank, blank, 0].
- Load Q=20, R=0 (100/5) → `done_o` exactly 17 cycles after the load edge; `show_r_i`=0 frame = q, blank, 2, 0; `show_r_i`=1 frame = r, blank, blank, 0.
- Load Q=6, R=2 (44/7), then Q=22, R=4 (202/9) back-to-back at an 18-cycle spacing → both accepted; final frames "q 22" and "r  4".
- Load Q=255, R=100 → frames "q255" and "r100", with no blanking of the internal zeros in 100.
- `load_i` pulses at cycles 3 and 9 after an accepted load → ignored; the result matches the first load; exactly one `done_o` pulse.
- Assert `rst` at cycle 8 of a conversion → outputs return to reset values asynchronously; no `done_o`; the next load converts correctly.
